// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller with IR, BYPASS, IDCODE and one USER data register.
// Capture/shift on tck rising edge; tdo and register updates on tck falling edge.
module jtag_tap_ctrl #(
    parameter int unsigned IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1ABC_D0E1,
    parameter int unsigned USER_WIDTH = 8
) (
    input  logic                  tck,
    input  logic                  trst,
    input  logic                  tms,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_en,
    output logic [IR_WIDTH-1:0]   ir_q,
    output logic [USER_WIDTH-1:0] user_q,
    output logic [3:0]            tap_state
);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR,
        UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_e;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_USER   = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] IR_CAPT   = IR_WIDTH'(4'b0101);

    tap_e state, state_nxt;

    logic [IR_WIDTH-1:0]   ir_sr;
    logic [31:0]           id_sr;
    logic [USER_WIDTH-1:0] usr_sr;
    logic                  bp_sr;
    logic                  sel_idcode;
    logic                  sel_user;
    logic                  dr_lsb;

    assign tap_state  = state;
    assign sel_idcode = (ir_q == IR_IDCODE);
    assign sel_user   = (ir_q == IR_USER);

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) state <= TLR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            TLR:    state_nxt = tms ? TLR    : RTI;
            RTI:    state_nxt = tms ? SEL_DR : RTI;
            SEL_DR: state_nxt = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_nxt = tms ? EX1_DR : SH_DR;
            SH_DR:  state_nxt = tms ? EX1_DR : SH_DR;
            EX1_DR: state_nxt = tms ? UPD_DR : PA_DR;
            PA_DR:  state_nxt = tms ? EX2_DR : PA_DR;
            EX2_DR: state_nxt = tms ? UPD_DR : SH_DR;
            UPD_DR: state_nxt = tms ? SEL_DR : RTI;
            SEL_IR: state_nxt = tms ? TLR    : CAP_IR;
            CAP_IR: state_nxt = tms ? EX1_IR : SH_IR;
            SH_IR:  state_nxt = tms ? EX1_IR : SH_IR;
            EX1_IR: state_nxt = tms ? UPD_IR : PA_IR;
            PA_IR:  state_nxt = tms ? EX2_IR : PA_IR;
            EX2_IR: state_nxt = tms ? UPD_IR : SH_IR;
            UPD_IR: state_nxt = tms ? SEL_DR : RTI;
        endcase
    end

    always_comb begin
        dr_lsb = bp_sr;
        unique case (1'b1)
            sel_idcode: dr_lsb = id_sr[0];
            sel_user:   dr_lsb = usr_sr[0];
            default:    dr_lsb = bp_sr;
        endcase
    end

    // Only the selected DR moves; pause/exit states leave everything intact.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir_sr  <= '0;
            id_sr  <= '0;
            usr_sr <= '0;
            bp_sr  <= 1'b0;
        end else begin
            case (state)
                CAP_IR: ir_sr <= IR_CAPT;
                SH_IR:  ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
                CAP_DR: begin
                    bp_sr <= 1'b0;
                    unique case (1'b1)
                        sel_idcode: id_sr  <= IDCODE_VAL;
                        sel_user:   usr_sr <= user_q;
                        default:    ;
                    endcase
                end
                SH_DR: begin
                    unique case (1'b1)
                        sel_idcode: id_sr  <= {tdi, id_sr[31:1]};
                        sel_user:   usr_sr <= {tdi, usr_sr[USER_WIDTH-1:1]};
                        default:    bp_sr  <= tdi;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
            ir_q   <= IR_IDCODE;
            user_q <= '0;
        end else begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
            case (state)
                SH_IR: begin
                    tdo    <= ir_sr[0];
                    tdo_en <= 1'b1;
                end
                SH_DR: begin
                    tdo    <= dr_lsb;
                    tdo_en <= 1'b1;
                end
                UPD_IR: ir_q <= ir_sr;
                UPD_DR: if (sel_user) user_q <= usr_sr;
                TLR:    ir_q <= IR_IDCODE;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/jtag_tap_ctrl.md
JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 4, instruction register width (min 2).
REQ-002 SHALL have parameter IDCODE_VAL, default 32'h1ABC_D0E1, 32-bit device ID; bit0 is 1.
REQ-003 SHALL have parameter USER_WIDTH, default 8, user data register width.
REQ-004 SHALL have port tck  input  1  test clock, the only clock.
REQ-005 SHALL have port trst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tms  input  1  mode select, sampled on tck rising edge.
REQ-007 SHALL have port tdi  input  1  serial data in, sampled on tck rising edge.
REQ-008 SHALL have port tdo  output  1  serial data out, changes on tck falling edge only.
REQ-009 SHALL have port tdo_en  output  1  high while tdo carries valid shift data.
REQ-010 SHALL have port ir_q  output  IR_WIDTH  current (updated) instruction.
REQ-011 SHALL have port user_q  output  USER_WIDTH  user register parallel output.
REQ-012 SHALL have port tap_state  output  4  current TAP state encoding.

Function
REQ-013 SHALL implement the 16-state IEEE 1149.1 TAP FSM, advanced on tck rising edge by tms: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR; encodings 0..15 in that order.
REQ-014 SHALL reach TLR after 5 consecutive rising edges with tms=1 from any state.
REQ-015 SHALL decode instructions: all-ones = BYPASS, 1 = IDCODE, 2 = USER; any other value selects BYPASS.
REQ-016 SHALL in CAP_IR load IR shift register with ...0101 (LSBs 01, upper bits 0).
REQ-017 SHALL in SH_IR shift right one bit per rising edge, tdi entering MSB, LSB feeding tdo.
REQ-018 SHALL in UPD_IR copy IR shift register to ir_q on the rising edge leaving UPD_IR is NOT used; ir_q updates on the tck falling edge while in UPD_IR.
REQ-019 SHALL in CAP_DR load the selected DR: BYPASS 1'b0, IDCODE IDCODE_VAL, USER current user_q.
REQ-020 SHALL in SH_DR shift the selected DR right, tdi into MSB, LSB to tdo; BYPASS gives exactly 1 cycle of tdi-to-tdo delay.
REQ-021 SHALL on the tck falling edge in UPD_DR with USER selected copy the user shift register to user_q; IDCODE/BYPASS updates have no effect.
REQ-022 SHALL register tdo and tdo_en on tck falling edge; tdo_en=1 only when state is SH_DR or SH_IR, else tdo=0, tdo_en=0.
REQ-023 SHALL hold shift registers unchanged in PA_DR/PA_IR and EX states (resumable shift).
REQ-024 SHALL on entering TLR (by tms) force ir_q to IDCODE on the tck falling edge in TLR; user_q is retained.
REQ-025 SHALL treat shifts longer than the register width as wrap-through (excess bits pass to tdo, last USER_WIDTH/32/IR_WIDTH tdi bits retained).

Reset
REQ-026 SHALL on trst=0 asynchronously force state TLR, ir_q=IDCODE (1), user_q=0, all shift registers 0, tdo=0, tdo_en=0.
REQ-027 SHALL resume FSM on the first tck rising edge after trst deasserts; trst mid-shift discards the shift without updating ir_q/user_q.

Verification
REQ-028 SHALL pass: trst pulse low, release, tms=0 then 1,0,0 (to SH_DR), 32 shifts -> tdo sequence LSB-first 32'h1ABC_D0E1, tdo_en=1 for 32 falling edges.
REQ-029 SHALL pass: load IR=4'hF via SH_IR, shift DR pattern 1,0,1,1 -> tdo emits 0 (capture) then 1,0,1 delayed by one cycle.
REQ-030 SHALL pass: load IR=2, shift 8'hA5 LSB-first, UPD_DR -> user_q=8'hA5; recapture and shift -> tdo returns 8'hA5.
REQ-031 SHALL pass: SH_IR capture -> first IR_WIDTH tdo bits are 1,0,1,0 (value 4'b0101).
REQ-032 SHALL pass: from SH_DR, 5 edges tms=1 -> tap_state=0, ir_q=1, user_q unchanged.
REQ-033 SHALL pass: trst asserted mid-SH_DR of USER -> tap_state=0 immediately, tdo=0, user_q=0, no UPD effect after release.
